// File: rtl/sound_pkg.sv
// Shared types and clip address table for the sound clip player.
// Clip bounds index the concatenated win_rom image.
package sound_pkg;

   localparam int CLIP_AW = 18;

   typedef enum logic [1:0] {
      CLIP_WIN    = 2'd0,
      CLIP_MOO    = 2'd1,
      CLIP_DETECT = 2'd2,
      CLIP_CHEER  = 2'd3
   } clip_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_PACE,
      S_DONE
   } state_e;

   typedef struct packed {
      logic [CLIP_AW-1:0] first;
      logic [CLIP_AW-1:0] last;
   } clip_rng_t;

   localparam logic [CLIP_AW-1:0] WIN_FIRST    = 18'd0;
   localparam logic [CLIP_AW-1:0] WIN_LAST     = 18'd16395;
   localparam logic [CLIP_AW-1:0] MOO_FIRST    = 18'd16396;
   localparam logic [CLIP_AW-1:0] MOO_LAST     = 18'd66982;
   localparam logic [CLIP_AW-1:0] DETECT_FIRST = 18'd66983;
   localparam logic [CLIP_AW-1:0] DETECT_LAST  = 18'd83254;
   localparam logic [CLIP_AW-1:0] CHEER_FIRST  = 18'd83255;
   localparam logic [CLIP_AW-1:0] CHEER_LAST   = 18'd137138;

   function automatic clip_rng_t clip_range(input clip_e c);
      clip_rng_t r;
      r.first = WIN_FIRST;
      r.last  = WIN_LAST;
      case (c)
         CLIP_WIN:    begin r.first = WIN_FIRST;    r.last = WIN_LAST;    end
         CLIP_MOO:    begin r.first = MOO_FIRST;    r.last = MOO_LAST;    end
         CLIP_DETECT: begin r.first = DETECT_FIRST; r.last = DETECT_LAST; end
         CLIP_CHEER:  begin r.first = CHEER_FIRST;  r.last = CHEER_LAST;  end
         default:     begin r.first = WIN_FIRST;    r.last = WIN_LAST;    end
      endcase
      return r;
   endfunction

endpackage

// File: rtl/sample_rate_div.sv
// Sample-period counter: counts 0..DIV-1, ticks on the last count,
// and restarts from 0 on reload so a period starts with each fetch.
module sample_rate_div #(
   parameter int DIV = 1200,
   parameter int CW  = $clog2(DIV)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          reload_i,
   output logic [CW-1:0] cnt_o,
   output logic          tick_o
);

   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // next count: reload wins, otherwise wrap at the last count
   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (reload_i || cnt_q == LAST) cnt_d = '0;
   end

   // count register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign cnt_o  = cnt_q;
   assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/sound_clip_player.sv
// Steps the audio ROM through a selected clip and feeds Audio_Controller.
// Define SOUND_LOOP_EN to let the loop input restart a clip at its end.
import sound_pkg::*;

module sound_clip_player #(
   parameter int CLK_DIV  = 1200,
   parameter int ADDR_W   = 18,
   parameter int SAMPLE_W = 6,
   parameter int ROM_LAT  = 2
) (
   input  logic                CLOCK_50,
   input  logic                resetn,
   input  logic                play_req,
   input  logic [1:0]          clip_sel,
   input  logic                stop,
   input  logic                loop,
   output logic [ADDR_W-1:0]   rom_addr,
   input  logic [SAMPLE_W-1:0] rom_q,
   input  logic                audio_out_allowed,
   output logic                write_audio_out,
   output logic [31:0]         left_channel_audio_out,
   output logic [31:0]         right_channel_audio_out,
   output logic                busy,
   output logic                done,
   output logic [7:0]          drop_cnt
);

   localparam int CW = $clog2(CLK_DIV);
   localparam logic [CW-1:0] LAT_C = CW'(ROM_LAT);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ADDR_W-1:0]   first_q, first_d;
   logic [ADDR_W-1:0]   last_q, last_d;
   logic [SAMPLE_W-1:0] sample_q, sample_d;
   logic                pend_q, pend_d;
   logic [7:0]          drop_q, drop_d;
   logic                reload;
   logic                tick;
   logic [CW-1:0]       cnt;
   logic                wr;
   logic                loop_go;
   clip_rng_t           rng;

   sample_rate_div #(.DIV(CLK_DIV), .CW(CW)) u_div (
      .clk_i    (CLOCK_50),
      .rst_i    (resetn),
      .reload_i (reload),
      .cnt_o    (cnt),
      .tick_o   (tick)
   );

`ifdef SOUND_LOOP_EN
   assign loop_go = loop;
`else
   assign loop_go = 1'b0 & loop;
`endif

   // strobe is gated directly by allowed so it can never fire into a full FIFO
   assign wr  = (state_q == S_PACE) && pend_q && audio_out_allowed;
   assign rng = clip_range(clip_e'(clip_sel));

   // next-state: stop beats a request, a request beats normal sequencing
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      first_d  = first_q;
      last_d   = last_q;
      sample_d = sample_q;
      pend_d   = pend_q;
      drop_d   = drop_q;
      reload   = 1'b0;
      if (stop) begin
         state_d = S_IDLE;
         pend_d  = 1'b0;
      end else if (play_req) begin
         state_d = S_FETCH;
         first_d = ADDR_W'(rng.first);
         last_d  = ADDR_W'(rng.last);
         addr_d  = ADDR_W'(rng.first);
         pend_d  = 1'b0;
         reload  = 1'b1;
      end else begin
         unique case (state_q)
            S_IDLE: ;
            S_FETCH: begin
               if (cnt == LAT_C) begin
                  sample_d = rom_q;
                  pend_d   = 1'b1;
                  state_d  = S_PACE;
               end
            end
            S_PACE: begin
               if (wr) pend_d = 1'b0;
               if (tick) begin
                  if (pend_q && !wr && drop_q != 8'hFF)
                     drop_d = drop_q + 8'd1;
                  pend_d = 1'b0;
                  if (addr_q == last_q) begin
                     state_d = S_DONE;
                  end else begin
                     addr_d  = addr_q + 1'b1;
                     state_d = S_FETCH;
                     reload  = 1'b1;
                  end
               end
            end
            S_DONE: begin
               if (loop_go) begin
                  addr_d  = first_q;
                  state_d = S_FETCH;
                  reload  = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // state and datapath registers
   always_ff @(posedge CLOCK_50 or posedge resetn) begin
      if (resetn) begin
         state_q  <= S_IDLE;
         addr_q   <= '0;
         first_q  <= '0;
         last_q   <= '0;
         sample_q <= '0;
         pend_q   <= 1'b0;
         drop_q   <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         first_q  <= first_d;
         last_q   <= last_d;
         sample_q <= sample_d;
         pend_q   <= pend_d;
         drop_q   <= drop_d;
      end
   end

   assign rom_addr                = addr_q;
   assign write_audio_out         = wr;
   assign left_channel_audio_out  = {sample_q, {(32-SAMPLE_W){1'b0}}};
   assign right_channel_audio_out = '0;
   assign busy                    = (state_q != S_IDLE);
   assign done                    = (state_q == S_DONE);
   assign drop_cnt                = drop_q;

endmodule
